// File: rtl/stream_mux_pkg.sv
// Shared helpers for the round-robin stream multiplexer.
// rot_prio_grant: rotating priority encoder. Scans req starting at ptr+1,
// wrapping through idx_mask (N-1 for an N-entry, power-of-two request
// vector), and returns a one-hot grant of the first set bit, or zero when
// nothing is requested. Vectors are fixed at 32 bits, so callers support up
// to 32 channels and zero-extend narrower request vectors.
package stream_mux_pkg;

  function automatic logic [31:0] rot_prio_grant(
    input logic [31:0] req,
    input logic [4:0]  ptr,
    input logic [4:0]  idx_mask
  );
    logic [31:0] gnt;
    logic        found;
    logic        take;
    logic [4:0]  idx;
    gnt   = 32'd0;
    found = 1'b0;
    // Visit ptr+1, ptr+2, ... ; the masked index repeats harmlessly once
    // the loop has wrapped, because only the first hit is taken.
    for (int k = 1; k <= 32; k++) begin
      idx      = (ptr + 5'(k)) & idx_mask;
      take     = req[idx] & ~found;
      gnt[idx] = gnt[idx] | take;
      found    = found | take;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter owning the rotating priority pointer.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req        - per-channel request
//   advance    - a round-robin grant was consumed this cycle
//   grant      - one-hot grant (zero when no request)
//   grant_idx  - binary index of grant (zero when no request)
// After reset the pointer sits at N_IN-1 so channel 0 has first priority.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  req,
  input  logic             advance,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] rr_ptr_q;
  logic [SEL_W-1:0] rr_ptr_d;
  logic [31:0]      req_ext_s;
  logic [31:0]      gnt_ext_s;
  logic             gnt_unused_s;

  // Rotating priority grant, computed at the shared 32-bit helper width.
  always_comb begin
    req_ext_s           = 32'd0;
    req_ext_s[N_IN-1:0] = req;
    gnt_ext_s           = rot_prio_grant(req_ext_s, 5'(rr_ptr_q), 5'(N_IN - 1));
    grant               = gnt_ext_s[N_IN-1:0];
    gnt_unused_s        = ^gnt_ext_s;
  end

  // One-hot to binary index of the granted channel.
  always_comb begin
    grant_idx = {SEL_W{1'b0}};
    for (int i = 0; i < N_IN; i++) begin
      grant_idx = grant_idx | ({SEL_W{grant[i]}} & SEL_W'(i));
    end
  end

  // The pointer moves to the winner only when its grant was consumed.
  always_comb begin
    if (advance) begin
      rr_ptr_d = grant_idx;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= SEL_W'(N_IN - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-input, one-output valid/ready stream multiplexer with one registered
// output stage. mode=0 selects channel sel; mode=1 arbitrates round-robin.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   mode, sel  - selection mode and fixed-mode channel index
//   in_valid / in_ready / in_data - N_IN input streams, channel i at
//                in_data[i*WIDTH +: WIDTH]; in_ready is combinational
//   out_valid / out_ready / out_data / out_chan - registered output stream
module rr_stream_mux #(
  parameter  int WIDTH = 4,
  parameter  int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_chan
);

  logic             load_s;
  logic             xfer_s;
  logic             advance_s;
  logic [N_IN-1:0]  rr_grant_s;
  logic [N_IN-1:0]  fix_grant_s;
  logic [N_IN-1:0]  grant_s;
  logic [SEL_W-1:0] rr_idx_s;
  logic [SEL_W-1:0] grant_idx_s;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_chan_q,  out_chan_d;

  rr_arbiter #(
    .N_IN (N_IN)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (advance_s),
    .grant     (rr_grant_s),
    .grant_idx (rr_idx_s)
  );

  // Grant selection and input handshake. in_ready is forced low during
  // reset so no input transfer completes in a reset cycle.
  always_comb begin
    load_s           = ~out_valid_q | out_ready;
    fix_grant_s      = {N_IN{1'b0}};
    fix_grant_s[sel] = in_valid[sel];
    if (mode) begin
      grant_s     = rr_grant_s;
      grant_idx_s = rr_idx_s;
    end else begin
      grant_s     = fix_grant_s;
      grant_idx_s = sel;
    end
    in_ready  = grant_s & {N_IN{load_s & ~rst}};
    xfer_s    = |(in_valid & in_ready);
    advance_s = xfer_s & mode;
  end

  // Output stage next state: load on a free or draining slot, hold on stall.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (load_s) begin
      out_valid_d = xfer_s;
      if (xfer_s) begin
        out_data_d = in_data[grant_idx_s*WIDTH +: WIDTH];
        out_chan_d = grant_idx_s;
      end else begin
        // slot empties; data and channel keep their last values
        out_data_d = out_data_q;
        out_chan_d = out_chan_q;
      end
    end else begin
      // stalled: hold everything
      out_valid_d = out_valid_q;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_chan_q  <= {SEL_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: a reference model predicts handshakes
// and pushes expected output beats; a monitor compares the output stream.
module tb_rr_stream_mux;

  localparam int WIDTH = 4;
  localparam int N_IN  = 4;
  localparam int SEL_W = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] chan;
  } item_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_chan;

  item_t            sb[$];
  int               seen[$];
  int               exp_q[$];
  int               checks   = 0;
  int               failures = 0;
  bit               m_valid  = 1'b0;
  int               m_ptr    = N_IN - 1;
  logic [WIDTH-1:0] ch_data [N_IN];

  always #5 clk = ~clk;

  rr_stream_mux #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
  );

  // Which channel the rules pick this cycle, or -1 for none.
  function automatic int model_grant(bit md, int s, logic [N_IN-1:0] v, int ptr);
    if (!md) return v[s] ? s : -1;
    for (int k = 1; k <= N_IN; k++) begin
      if (v[(ptr + k) % N_IN]) return (ptr + k) % N_IN;
    end
    return -1;
  endfunction

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_seq(string name, input int exp[$]);
    bit ok;
    checks++;
    ok = (seen.size() == exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (ok && seen[i] != exp[i]) ok = 1'b0;
    end
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%p required=%p", name, seen, exp);
    end
    seen.delete();
  endtask

  // One clock cycle: drive, predict and check the handshake, advance.
  task automatic cyc(input bit r, input bit md, input int s,
                     input logic [N_IN-1:0] v, input bit rdy);
    int             g;
    bit             load;
    logic [N_IN-1:0] exp_rdy;
    item_t          it;
    rst = r; mode = md; sel = s[SEL_W-1:0]; in_valid = v; out_ready = rdy;
    for (int c = 0; c < N_IN; c++) in_data[c*WIDTH +: WIDTH] = ch_data[c];
    #2;
    if (r) begin
      check_val("in_ready_rst", 32'(in_ready), 32'd0);
      sb.delete();
      m_valid = 1'b0;
      m_ptr   = N_IN - 1;
    end else begin
      check_val("out_valid", 32'(out_valid), 32'(m_valid));
      g       = model_grant(md, s, v, m_ptr);
      load    = !m_valid || rdy;
      exp_rdy = '0;
      if (load && g >= 0) exp_rdy[g] = 1'b1;
      check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (exp_rdy != '0) begin
        it.data = ch_data[g];
        it.chan = SEL_W'(g);
        sb.push_back(it);
        if (md) m_ptr = g;
        m_valid = 1'b1;
      end else if (load) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=chan%0d/data%0h required=none", out_chan, out_data);
      end else begin
        check_val("out_data", 32'(out_data), 32'(sb[0].data));
        check_val("out_chan", 32'(out_chan), 32'(sb[0].chan));
        if (out_ready === 1'b1) begin
          seen.push_back(int'(out_chan));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < N_IN; c++) ch_data[c] = WIDTH'(c + 1);

    // Reset then idle.
    cyc(1'b1, 1'b0, 0, 4'b0000, 1'b1);
    cyc(1'b1, 1'b0, 0, 4'b0000, 1'b1);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_out_chan", 32'(out_chan), 32'd0);
    cyc(1'b0, 1'b0, 0, 4'b0000, 1'b1);

    // Fixed select of channel 2.
    seen.delete();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 2, 4'b1111, 1'b1);
    check_val("fixed_data", 32'(out_data), 32'd3);
    check_val("fixed_chan", 32'(out_chan), 32'd2);
    cyc(1'b0, 1'b0, 2, 4'b0000, 1'b1);
    exp_q = '{2, 2, 2, 2, 2};
    check_seq("fixed_seq", exp_q);

    // Round-robin, all channels valid from reset.
    cyc(1'b1, 1'b1, 0, 4'b1111, 1'b1);
    seen.delete();
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 0, 4'b1111, 1'b1);
    cyc(1'b0, 1'b1, 0, 4'b0000, 1'b1);
    exp_q = '{0, 1, 2, 3, 0, 1};
    check_seq("rr_all_seq", exp_q);

    // Round-robin, sparse requests, then ch3 drops.
    cyc(1'b1, 1'b1, 0, 4'b0000, 1'b1);
    seen.delete();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 0, 4'b1010, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 0, 4'b0010, 1'b1);
    cyc(1'b0, 1'b1, 0, 4'b0000, 1'b1);
    exp_q = '{1, 3, 1, 3, 1, 1};
    check_seq("rr_sparse_seq", exp_q);

    // Back-pressure holding ch0 value 5.
    cyc(1'b1, 1'b1, 0, 4'b0000, 1'b1);
    seen.delete();
    ch_data[0] = WIDTH'(5);
    cyc(1'b0, 1'b1, 0, 4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 0, 4'b0011, 1'b0);
    check_val("bp_hold_data", 32'(out_data), 32'd5);
    cyc(1'b0, 1'b1, 0, 4'b0011, 1'b1);
    check_val("bp_next_chan", 32'(out_chan), 32'd1);
    cyc(1'b0, 1'b1, 0, 4'b0000, 1'b1);
    exp_q = '{0, 1};
    check_seq("bp_seq", exp_q);
    ch_data[0] = WIDTH'(1);

    // Mode switch 1->0 (sel=0) while ch2 is in the output register.
    cyc(1'b1, 1'b1, 0, 4'b0000, 1'b1);
    seen.delete();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 0, 4'b1111, 1'b1);
    cyc(1'b0, 1'b0, 0, 4'b1111, 1'b1);
    cyc(1'b0, 1'b0, 0, 4'b0000, 1'b1);
    exp_q = '{0, 1, 2, 0};
    check_seq("mode_switch_seq", exp_q);

    // Reset while the output is occupied.
    cyc(1'b0, 1'b1, 0, 4'b1111, 1'b1);
    cyc(1'b0, 1'b1, 0, 4'b1111, 1'b1);
    cyc(1'b1, 1'b1, 0, 4'b1111, 1'b1);
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_chan", 32'(out_chan), 32'd0);
    seen.delete();
    cyc(1'b0, 1'b1, 0, 4'b1111, 1'b1);
    cyc(1'b0, 1'b1, 0, 4'b0000, 1'b1);
    exp_q = '{0};
    check_seq("post_rst_seq", exp_q);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N_IN; c++) ch_data[c] = WIDTH'($urandom);
      cyc(($urandom_range(0, 39) == 0), 1'($urandom), int'($urandom_range(0, N_IN - 1)),
          N_IN'($urandom), ($urandom_range(0, 3) != 0));
    end
    cyc(1'b0, 1'b0, 0, 4'b0000, 1'b1);
    cyc(1'b0, 1'b0, 0, 4'b0000, 1'b1);
    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
